// File: rtl/hilo_muldiv_unit.sv
// Multicycle signed multiply/divide unit feeding the HI/LO registers.
// Radix-2 Booth multiply or restoring divide, one bit per clock, with a divide-by-zero flag.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    hd_control,
  input  logic signed [WIDTH-1:0] a_in,
  input  logic signed [WIDTH-1:0] b_in,
  output logic        [WIDTH-1:0] hi_out,
  output logic        [WIDTH-1:0] lo_out,
  output logic                    busy,
  output logic                    done,
  output logic                    div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]        cnt;
  logic [2*WIDTH:0]        acc;
  logic signed [WIDTH-1:0] mcand;
  logic [WIDTH-1:0]        rem;
  logic [WIDTH-1:0]        quo;
  logic [WIDTH-1:0]        dvsr;
  logic                    quo_neg;
  logic                    rem_neg;
  logic                    dz_flag;

  logic signed [WIDTH:0]   booth_hi;
  logic signed [WIDTH:0]   booth_mc;
  logic signed [WIDTH:0]   booth_sum;
  logic [2*WIDTH:0]        acc_next;
  logic [WIDTH:0]          div_shift;
  logic                    div_fits;
  logic [WIDTH-1:0]        rem_next;
  logic [WIDTH-1:0]        quo_next;
  logic                    last_iter;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Booth step: the upper half is widened by one bit so subtracting the most
  // negative multiplicand cannot overflow before the arithmetic shift.
  always_comb begin
    booth_hi = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    booth_mc = {mcand[WIDTH-1], mcand};
    case (acc[1:0])
      2'b01:   booth_sum = booth_hi + booth_mc;
      2'b10:   booth_sum = booth_hi - booth_mc;
      default: booth_sum = booth_hi;
    endcase
    acc_next = {booth_sum, acc[WIDTH:1]};
  end

  // Restoring divide step; the partial remainder always stays below the divisor.
  always_comb begin
    div_shift = {rem, quo[WIDTH-1]};
    div_fits  = (div_shift >= {1'b0, dvsr});
    rem_next  = div_fits ? WIDTH'(div_shift - {1'b0, dvsr}) : WIDTH'(div_shift);
    quo_next  = {quo[WIDTH-2:0], div_fits};
  end

  assign last_iter = ((state == MULT) || (state == DIV)) && (cnt == LAST_CNT);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (!hd_control)        state_next = MULT;
          else if (b_in != '0)    state_next = DIV;
          else                    state_next = FINISH;
        end
      end
      MULT, DIV: begin
        if (cnt == LAST_CNT) state_next = FINISH;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign done        = (state == FINISH);
  assign div_by_zero = (state == FINISH) && dz_flag;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      quo_neg <= 1'b0;
      rem_neg <= 1'b0;
      dz_flag <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          dz_flag <= 1'b0;
          if (start) begin
            cnt <= '0;
            if (!hd_control) begin
              acc   <= {{WIDTH{1'b0}}, b_in, 1'b0};
              mcand <= a_in;
            end else if (b_in != '0) begin
              rem     <= '0;
              quo     <= magnitude(a_in);
              dvsr    <= magnitude(b_in);
              quo_neg <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
              rem_neg <= a_in[WIDTH-1];
            end else begin
              dz_flag <= 1'b1;
            end
          end
        end
        MULT: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            hi_out <= acc_next[2*WIDTH:WIDTH+1];
            lo_out <= acc_next[WIDTH:1];
          end
        end
        DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            hi_out <= apply_sign(rem_next, rem_neg);
            lo_out <= apply_sign(quo_next, quo_neg);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: stimulus pushes expected HI/LO/flag,
// a negedge monitor pops and compares on every done pulse.
module tb_hilo_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        hd_control;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .hd_control  (hd_control),
    .a_in        (a_in),
    .b_in        (b_in),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_done: got done=1 expected no pending operation");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_hi"}, 64'(hi_out), 64'(e.hi));
        check({e.name, "_lo"}, 64'(lo_out), 64'(e.lo));
        check({e.name, "_dz"}, 64'(div_by_zero), 64'(e.dz));
      end
    end
  end

  task automatic run_op(input string name, input logic hd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int elat, input int inj1, input int inj2);
    int   lat;
    exp_t e;
    @(negedge clock);
    start = 1'b1; hd_control = hd; a_in = a; b_in = b;
    e.hi = ehi; e.lo = elo; e.dz = edz; e.name = name;
    exp_q.push_back(e);
    @(posedge clock);
    @(negedge clock);
    lat = 0;
    while (1) begin
      if (lat == inj1 || lat == inj2) begin
        start = 1'b1; hd_control = 1'b1; a_in = 32'd99; b_in = 32'd0;
      end else begin
        start = 1'b0; hd_control = ~hd; a_in = $urandom; b_in = $urandom;
      end
      if (lat == 1) check({name, "_busy_mid"}, 64'(busy), 64'd1);
      if (done || lat >= 64) break;
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    check({name, "_done_seen"}, 64'(done), 64'd1);
    check({name, "_latency"}, 64'(lat), 64'(elat));
    @(negedge clock);
    start = 1'b0;
    check({name, "_busy_after"}, 64'(busy), 64'd0);
    check({name, "_done_after"}, 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int dc0;
    reset = 1'b1; start = 1'b0; hd_control = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_hi",   64'(hi_out), 64'd0);
    check("rst_lo",   64'(lo_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz",   64'(div_by_zero), 64'd0);
    reset = 1'b0;

    run_op("mul_7_m3",   1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 32, -1, -1);
    run_op("mul_min_min",1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 32, -1, -1);
    run_op("mul_zero",   1'b0, 32'd0,        32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 32, -1, -1);
    run_op("mul_m1_m1",  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 32, -1, -1);
    run_op("mul_max_min",1'b0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, 32, -1, -1);
    run_op("div_m7_2",   1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32, -1, -1);
    run_op("div_100_7",  1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 32, -1, -1);
    run_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 32, -1, -1);
    run_op("div_7_m2",   1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 32, -1, -1);
    run_op("div_setup",  1'b1, 32'h451,      32'h20,       32'h11,       32'h22,       1'b0, 32, -1, -1);
    run_op("div_by_0",   1'b1, 32'd5,        32'd0,        32'h11,       32'h22,       1'b1, 0,  -1, -1);

    // Abort a divide ten cycles in; no completion may follow.
    dc0 = done_cnt;
    @(negedge clock);
    start = 1'b1; hd_control = 1'b1; a_in = 32'd1000; b_in = 32'd3;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (10) begin @(posedge clock); @(negedge clock); end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("abort_hi",   64'(hi_out), 64'd0);
    check("abort_lo",   64'(lo_out), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (40) @(negedge clock);
    check("abort_no_done", 64'(done_cnt - dc0), 64'd0);

    run_op("mul_3_4", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 32, -1, -1);

    // Rogue start requests mid-operation and in FINISH are ignored.
    dc0 = done_cnt;
    run_op("mul_rogue", 1'b0, 32'h1234, 32'h10, 32'd0, 32'h12340, 1'b0, 32, 5, 32);
    repeat (40) @(negedge clock);
    check("rogue_one_done", 64'(done_cnt - dc0), 64'd1);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
